// File: rtl/bloom_pkg.sv
// Shared types and constants for the Bloom filter engine.
// Optional build macro: BLOOM_EARLY_EXIT_EN (CHECK stops hashing at the first zero bit).
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_INSERT = 2'b01,
    OP_CHECK  = 2'b10,
    OP_CLEAR  = 2'b11
  } bloom_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HASH  = 2'b01,
    ST_CLEAR = 2'b10,
    ST_RESP  = 2'b11
  } bloom_state_e;

  localparam logic [31:0] HASH_MULT = 32'h045D9F3B;

  // One seed per hash function; K_HASH selects how many are used.
  localparam logic [31:0] SEED [0:7] = '{
    32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5CEDC834,
    32'hB5297A4D, 32'h68E31DA4, 32'h1B56C4E9, 32'hD2A98B26
  };

endpackage

// File: rtl/bloom_hash.sv
// Seeded xor-shift-multiply hash producing one bit-array index.
// Purely combinational; the engine shares one instance across its hash cycles.
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [31:0]      data,
  input  logic [31:0]      seed,
  output logic [IDX_W-1:0] idx
);

  logic [31:0] mix_s;
  logic [31:0] fold_s;
  logic [31:0] prod_s;

  // Mix key with seed, fold the high half down, multiply; top bits are best mixed.
  always_comb begin
    mix_s  = data ^ seed;
    fold_s = mix_s ^ (mix_s >> 16);
    prod_s = fold_s * HASH_MULT;
    idx    = prod_s[31 -: IDX_W];
  end

endmodule

// File: rtl/bloom_filter_unit.sv
// Multi-cycle Bloom filter engine (INSERT / CHECK / CLEAR / NOP) for the EX path.
// One hash index per cycle through a shared bloom_hash, M_BITS array held as 32-bit words.
// Optional build macro: BLOOM_EARLY_EXIT_EN -- a CHECK leaves HASH right after the
// first zero bit is read; when undefined every CHECK evaluates all K_HASH indices.
module bloom_filter_unit
  import bloom_pkg::*;
#(
  parameter int M_BITS = 256,
  parameter int K_HASH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  output logic        resp_match_o,
  output logic        busy_o
);

  localparam int IDX_W  = $clog2(M_BITS);
  localparam int WORDS  = M_BITS / 32;
  localparam int WORD_W = $clog2(WORDS);
  // Counter must reach both the last word and the last hash (up to 8 hashes).
  localparam int CNT_W  = (WORD_W > 3) ? WORD_W : 3;
  localparam logic [CNT_W-1:0] HASH_LAST = CNT_W'(K_HASH - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORDS - 1);

  bloom_state_e     state_r, next_state_s;
  bloom_op_e        op_r;
  logic [31:0]      data_r;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             match_acc_r, match_next_s;
  logic [31:0]      words_r [WORDS];
  logic             ready_r, busy_r, resp_valid_r, resp_match_r;
  logic [IDX_W-1:0] idx_s;
  logic             bit_s;
  logic             accept_s;

  assign accept_s = req_valid_i && (state_r == ST_IDLE);

  bloom_hash #(.IDX_W(IDX_W)) u_hash (
    .data (data_r),
    .seed (SEED[cnt_r[2:0]]),
    .idx  (idx_s)
  );

  // Combinational read of the addressed membership bit.
  always_comb begin
    bit_s = words_r[idx_s[IDX_W-1:5]][idx_s[4:0]];
  end

  // Next-state, counter and match-accumulator logic.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    match_next_s = match_acc_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          cnt_next_s   = {CNT_W{1'b0}};
          match_next_s = 1'b1;
          case (bloom_op_e'(req_op_i))
            OP_INSERT: next_state_s = ST_HASH;
            OP_CHECK:  next_state_s = ST_HASH;
            OP_CLEAR:  next_state_s = ST_CLEAR;
            OP_NOP:    next_state_s = ST_RESP;
            default:   next_state_s = ST_IDLE;
          endcase
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HASH: begin
        if (op_r == OP_CHECK) begin
          match_next_s = match_acc_r & bit_s;
        end else begin
          match_next_s = match_acc_r;
        end
        if (cnt_r == HASH_LAST) begin
          next_state_s = ST_RESP;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
`ifdef BLOOM_EARLY_EXIT_EN
        if ((op_r == OP_CHECK) && !bit_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = next_state_s;
        end
`endif
      end
      ST_CLEAR: begin
        if (cnt_r == WORD_LAST) begin
          next_state_s = ST_RESP;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operation latches, counter and match accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r        <= OP_NOP;
      data_r      <= 32'h0;
      cnt_r       <= {CNT_W{1'b0}};
      match_acc_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r   <= bloom_op_e'(req_op_i);
        data_r <= req_data_i;
      end
      cnt_r       <= cnt_next_s;
      match_acc_r <= match_next_s;
    end
  end

  // Membership array: set a bit per INSERT hash cycle, wipe one word per CLEAR cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < WORDS; w++) begin
        words_r[w] <= 32'h0;
      end
    end else if ((state_r == ST_HASH) && (op_r == OP_INSERT)) begin
      words_r[idx_s[IDX_W-1:5]][idx_s[4:0]] <= 1'b1;
    end else if (state_r == ST_CLEAR) begin
      words_r[cnt_r[WORD_W-1:0]] <= 32'h0;
    end
  end

  // Registered handshake/status outputs, decoded from the upcoming state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_match_r <= 1'b0;
    end else begin
      ready_r      <= (next_state_s == ST_IDLE);
      busy_r       <= (next_state_s != ST_IDLE);
      resp_valid_r <= (next_state_s == ST_RESP);
      // Only a CHECK reaches RESP from HASH with a meaningful match.
      resp_match_r <= (next_state_s == ST_RESP) && (state_r == ST_HASH) &&
                      (op_r == OP_CHECK) && match_next_s;
    end
  end

  assign req_ready_o  = ready_r;
  assign busy_o       = busy_r;
  assign resp_valid_o = resp_valid_r;
  assign resp_match_o = resp_match_r;

endmodule
